// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: N integrators, N pipelined combs, self-generated
// decimation strobe, gain normalisation with rounding/saturation, flush on rate change.
module cic_decim_mc #(
    parameter int BW_IN         = 16,
    parameter int BW_OUT        = 16,
    parameter int N             = 4,
    parameter int LOG2_MAX_RATE = 7,
    parameter int NCH           = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [LOG2_MAX_RATE-1:0] rate,
    input  logic                     strobe_in,
    input  logic [NCH*BW_IN-1:0]     signal_in,
    output logic                     strobe_out,
    output logic [NCH*BW_OUT-1:0]    signal_out,
    output logic                     overflow
);
    localparam int W  = BW_IN + N*LOG2_MAX_RATE;
    localparam int FW = $clog2(N+1);
    localparam logic signed [W:0] ONE  = (W+1)'(1);
    localparam logic signed [W:0] VMAX = (W+1)'((longint'(1) <<< (BW_OUT-1)) - 1);
    localparam logic signed [W:0] VMIN = ~VMAX;

    // ceil(log2(rate+1)), with D=1 giving 0
    function automatic int clog2_d(input logic [LOG2_MAX_RATE-1:0] r);
        int d;
        int k;
        d = int'(r) + 1;
        k = 0;
        for (int i = 0; i < LOG2_MAX_RATE; i++)
            if ((1 << i) < d) k = i + 1;
        return k;
    endfunction

    // Returns {saturated, value}; rounds half up before clipping.
    function automatic logic [BW_OUT:0] round_sat(input logic signed [W-1:0] c, input int s);
        logic signed [W:0] t;
        t = {c[W-1], c};
        if (s > 0)
            t = (t + (ONE <<< (s-1))) >>> s;
        if (t > VMAX)
            return {1'b1, VMAX[BW_OUT-1:0]};
        else if (t < VMIN)
            return {1'b1, VMIN[BW_OUT-1:0]};
        else
            return {1'b0, t[BW_OUT-1:0]};
    endfunction

    logic signed [W-1:0]        in_ext   [NCH];
    logic signed [W-1:0]        integ    [NCH][N];
    logic [LOG2_MAX_RATE-1:0]   rate_l;
    logic [LOG2_MAX_RATE-1:0]   cnt;
    logic [FW-1:0]              flush;
    logic                       tick_p0;
    logic signed [W-1:0]        samp_p1  [NCH];
    logic                       vld_p1;
    logic signed [W-1:0]        comb_x   [NCH][N];
    logic signed [W-1:0]        comb_y   [NCH][N];
    logic signed [W-1:0]        comb_dly [NCH][N];
    logic [N-1:0]               comb_vld;
    logic [N-1:0]               comb_in_vld;
    logic [NCH*BW_OUT-1:0]      norm_val;
    logic                       norm_ovf;
    logic [BW_OUT:0]            rs;
    logic                       strobe_q;
    logic                       ovf_q;
    logic                       rate_chg;
    int                         norm_s;

    always_comb begin
        for (int ch = 0; ch < NCH; ch++)
            in_ext[ch] = W'($signed(signal_in[ch*BW_IN +: BW_IN]));
    end

    always_comb begin
        comb_in_vld = '0;
        comb_in_vld[0] = vld_p1;
        for (int k = 1; k < N; k++)
            comb_in_vld[k] = comb_vld[k-1];
        for (int ch = 0; ch < NCH; ch++) begin
            comb_x[ch][0] = samp_p1[ch];
            for (int k = 1; k < N; k++)
                comb_x[ch][k] = comb_y[ch][k-1];
        end
    end

    always_comb begin
        rs       = '0;
        norm_val = '0;
        norm_ovf = 1'b0;
        norm_s   = N * clog2_d(rate_l) + BW_IN - BW_OUT;
        for (int ch = 0; ch < NCH; ch++) begin
            rs = round_sat(comb_y[ch][N-1], norm_s);
            norm_val[ch*BW_OUT +: BW_OUT] = rs[BW_OUT-1:0];
            norm_ovf = norm_ovf | rs[BW_OUT];
        end
    end

    assign rate_chg = (rate != rate_l);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                samp_p1[ch] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ[ch][k]    <= '0;
                    comb_y[ch][k]   <= '0;
                    comb_dly[ch][k] <= '0;
                end
            end
            rate_l     <= '0;
            cnt        <= '0;
            flush      <= '0;
            tick_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            comb_vld   <= '0;
            strobe_q   <= 1'b0;
            ovf_q      <= 1'b0;
            signal_out <= '0;
        end else if (enable) begin
            // integrators run regardless of rate changes
            if (strobe_in) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    integ[ch][0] <= integ[ch][0] + in_ext[ch];
                    for (int k = 1; k < N; k++)
                        integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
                end
            end
            if (rate_chg) begin
                rate_l   <= rate;
                cnt      <= rate;
                flush    <= FW'(N);
                tick_p0  <= 1'b0;
                vld_p1   <= 1'b0;
                comb_vld <= '0;
                strobe_q <= 1'b0;
                ovf_q    <= 1'b0;
                for (int ch = 0; ch < NCH; ch++)
                    for (int k = 0; k < N; k++) begin
                        comb_y[ch][k]   <= '0;
                        comb_dly[ch][k] <= '0;
                    end
            end else begin
                // p0: decimation tick
                tick_p0 <= strobe_in && (cnt == '0);
                if (strobe_in)
                    cnt <= (cnt == '0) ? rate_l : cnt - LOG2_MAX_RATE'(1);
                // p1: sample last integrator
                vld_p1 <= tick_p0;
                if (tick_p0)
                    for (int ch = 0; ch < NCH; ch++)
                        samp_p1[ch] <= integ[ch][N-1];
                // comb stages: one token-gated register each
                comb_vld <= comb_in_vld;
                for (int ch = 0; ch < NCH; ch++)
                    for (int k = 0; k < N; k++)
                        if (comb_in_vld[k]) begin
                            comb_y[ch][k]   <= comb_x[ch][k] - comb_dly[ch][k];
                            comb_dly[ch][k] <= comb_x[ch][k];
                        end
                // output stage: normalise, or swallow while flushing
                strobe_q <= 1'b0;
                ovf_q    <= 1'b0;
                if (comb_vld[N-1]) begin
                    if (flush != '0) begin
                        flush <= flush - FW'(1);
                    end else begin
                        strobe_q   <= 1'b1;
                        ovf_q      <= norm_ovf;
                        signal_out <= norm_val;
                    end
                end
            end
        end else begin
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
        end
    end

    assign strobe_out = strobe_q & enable;
    assign overflow   = ovf_q & enable;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: two instances (16- and 12-bit outputs) against a
// sample-level CIC reference model with output-time bookkeeping.
module tb_cic_decim_mc;
    localparam int N   = 4;
    localparam int L   = 7;
    localparam int NCH = 2;
    localparam int BWI = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset_n;
    logic                enable;
    logic                strobe_in;
    logic [L-1:0]        rate;
    logic signed [15:0]  din0;
    logic signed [15:0]  din1;
    logic [31:0]         signal_in;
    assign signal_in = {din1, din0};

    logic        stb16, ovf16, stb12, ovf12;
    logic [31:0] so16;
    logic [23:0] so12;

    cic_decim_mc #(.BW_IN(16), .BW_OUT(16), .N(N), .LOG2_MAX_RATE(L), .NCH(NCH)) dut16 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .signal_in(signal_in),
        .strobe_out(stb16), .signal_out(so16), .overflow(ovf16));

    cic_decim_mc #(.BW_IN(16), .BW_OUT(12), .N(N), .LOG2_MAX_RATE(L), .NCH(NCH)) dut12 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .rate(rate),
        .strobe_in(strobe_in), .signal_in(signal_in),
        .strobe_out(stb12), .signal_out(so12), .overflow(ovf12));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     due;
        longint c0;
        longint c1;
    } tok_t;

    longint m_integ [NCH][N];
    longint m_cdly  [NCH][N];
    int     m_cnt, m_rate_l, m_flush, m_edge;
    tok_t   pend[$];
    logic   e_stb, e_ovf16, e_ovf12;
    longint e16 [NCH];
    longint e12 [NCH];

    function automatic longint wrapw(input longint x);
        longint m;
        m = x & 64'h00000FFFFFFFFFFF;
        if (m[43]) m = m - (longint'(1) <<< 44);
        return m;
    endfunction

    task automatic norm(input longint c, input int rl, input int bw, output longint v, output logic o);
        int d, g, s;
        longint hi, lo;
        d = 1; g = 0;
        while (d < rl + 1) begin d = d * 2; g = g + N; end
        s = g + BWI - bw;
        v = (s > 0) ? ((c + (longint'(1) <<< (s-1))) >>> s) : c;
        hi = (longint'(1) <<< (bw-1)) - 1;
        lo = -hi - 1;
        o = 1'b0;
        if (v > hi) begin v = hi; o = 1'b1; end
        else if (v < lo) begin v = lo; o = 1'b1; end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < N; k++) begin m_integ[ch][k] = 0; m_cdly[ch][k] = 0; end
            e16[ch] = 0; e12[ch] = 0;
        end
        m_cnt = 0; m_rate_l = 0; m_flush = 0; m_edge = 0;
        pend.delete();
        e_stb = 1'b0; e_ovf16 = 1'b0; e_ovf12 = 1'b0;
    endtask

    // Predicts outputs after the coming clock edge from the inputs now applied.
    task automatic model_edge();
        longint ni [NCH][N];
        longint x, y, v, c;
        tok_t   t;
        logic   rc, o;
        e_stb = 1'b0; e_ovf16 = 1'b0; e_ovf12 = 1'b0;
        if (!enable) return;
        rc = (int'(rate) != m_rate_l);
        if (rc) begin
            pend.delete();
            for (int ch = 0; ch < NCH; ch++)
                for (int k = 0; k < N; k++) m_cdly[ch][k] = 0;
            m_flush = N; m_rate_l = int'(rate); m_cnt = m_rate_l;
        end else if (pend.size() > 0 && pend[0].due == m_edge) begin
            t = pend.pop_front();
            if (m_flush > 0) m_flush--;
            else begin
                e_stb = 1'b1;
                for (int ch = 0; ch < NCH; ch++) begin
                    c = (ch == 0) ? t.c0 : t.c1;
                    norm(c, m_rate_l, 16, v, o); e16[ch] = v; e_ovf16 = e_ovf16 | o;
                    norm(c, m_rate_l, 12, v, o); e12[ch] = v; e_ovf12 = e_ovf12 | o;
                end
            end
        end
        if (strobe_in) begin
            for (int ch = 0; ch < NCH; ch++) begin
                ni[ch][0] = wrapw(m_integ[ch][0] + ((ch == 0) ? longint'(din0) : longint'(din1)));
                for (int k = 1; k < N; k++) ni[ch][k] = wrapw(m_integ[ch][k] + m_integ[ch][k-1]);
            end
            m_integ = ni;
            if (!rc) begin
                if (m_cnt == 0) begin
                    m_cnt = m_rate_l;
                    t.due = m_edge + N + 2;
                    t.c0 = 0; t.c1 = 0;
                    for (int ch = 0; ch < NCH; ch++) begin
                        x = m_integ[ch][N-1];
                        for (int k = 0; k < N; k++) begin
                            y = wrapw(x - m_cdly[ch][k]);
                            m_cdly[ch][k] = x;
                            x = y;
                        end
                        if (ch == 0) t.c0 = x; else t.c1 = x;
                    end
                    pend.push_back(t);
                end else begin
                    m_cnt--;
                end
            end
        end
        m_edge++;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("strobe16", longint'(stb16), longint'(e_stb));
        chk("strobe12", longint'(stb12), longint'(e_stb));
        chk("ovf16", longint'(ovf16), longint'(e_ovf16));
        chk("ovf12", longint'(ovf12), longint'(e_ovf12));
        chk("out16_ch0", longint'($signed(so16[15:0])), e16[0]);
        chk("out16_ch1", longint'($signed(so16[31:16])), e16[1]);
        chk("out12_ch0", longint'($signed(so12[11:0])), e12[0]);
        chk("out12_ch1", longint'($signed(so12[23:12])), e12[1]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; strobe_in = 1'b0; rate = '0; din0 = '0; din1 = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset_n = 1'b1;

        // DC +/-1000 at D=8, strobe every clock
        enable = 1'b1; rate = 7; strobe_in = 1'b1; din0 = 1000; din1 = -1000;
        repeat (120) step();
        chk("dc8_ch0", longint'($signed(so16[15:0])), 1000);
        chk("dc8_ch1", longint'($signed(so16[31:16])), -1000);

        // D=1 ramp on ch0
        rate = 0; din1 = 0;
        for (int i = 0; i < 40; i++) begin din0 = 16'(i); step(); end

        // saturation at full-scale positive, then full-scale negative
        rate = 3; din0 = 32767; din1 = 32767;
        repeat (80) step();
        chk("sat_pos12", longint'($signed(so12[11:0])), 2047);
        din0 = -32768; din1 = -32768;
        repeat (80) step();
        chk("sat_neg12", longint'($signed(so12[11:0])), -2048);
        chk("neg16", longint'($signed(so16[15:0])), -32768);

        // strobe on every other clock, DC 500
        din0 = 500; din1 = 500;
        for (int i = 0; i < 120; i++) begin strobe_in = i[0]; step(); end
        chk("dc_half_rate", longint'($signed(so16[15:0])), 500);

        // rate change 7 -> 15 mid-stream
        strobe_in = 1'b1; rate = 7; din0 = 1000; din1 = 1000;
        repeat (100) step();
        rate = 15;
        repeat (200) step();
        chk("dc16_after_change", longint'($signed(so16[15:0])), 1000);

        // randomised stream with occasional rate changes and enable gaps
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) rate = L'($urandom_range(0, 31));
            enable    = ($urandom_range(0, 9) != 0);
            strobe_in = ($urandom_range(0, 9) < 7);
            din0 = 16'($urandom);
            din1 = 16'($urandom);
            step();
        end

        // asynchronous reset with tokens in flight
        enable = 1'b1; strobe_in = 1'b1; rate = 0;
        repeat (20) begin din0 = 16'($urandom); din1 = 16'($urandom); step(); end
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_strobe16", longint'(stb16), 0);
        chk("rst_strobe12", longint'(stb12), 0);
        chk("rst_out16", longint'(so16), 0);
        chk("rst_out12", longint'(so12), 0);
        chk("rst_ovf12", longint'(ovf12), 0);
        #1 reset_n = 1'b1;
        repeat (20) begin din0 = 16'($urandom); din1 = 16'($urandom); step(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
